// File: rtl/dense_tile_scheduler.sv
// Walks one dense_core over a layer: OC tiles outer, IC tiles inner; load -> start -> run -> flush.
// Registered outputs; load/flush requests hold until acknowledged, core_done is waited for in RUN only.
module dense_tile_scheduler #(
  parameter int OC_TILE = 32,
  parameter int IC_TILE = 64,
  parameter int IDX_W   = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [9:0]       TOTAL_IC,
  input  logic [9:0]       TOTAL_OC,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             load_req,
  input  logic             load_ack,
  output logic [IDX_W-1:0] load_oc_idx,
  output logic [IDX_W-1:0] load_ic_idx,
  output logic             core_start,
  input  logic             core_done,
  output logic [7:0]       core_oc,
  output logic [9:0]       core_ic,
  output logic             psum_clear,
  output logic             psum_last,
  output logic             flush_req,
  input  logic             flush_ack,
  output logic [IDX_W-1:0] flush_oc_idx
);

  localparam int OC_SH = $clog2(OC_TILE);
  localparam int IC_SH = $clog2(IC_TILE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_RUN, S_FLUSH, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [9:0]       tot_ic_q, tot_ic_d, tot_oc_q, tot_oc_d;
  logic [IDX_W-1:0] ic_last_q, ic_last_d, oc_last_q, oc_last_d;
  logic [IDX_W-1:0] ic_idx_q, ic_idx_d, oc_idx_q, oc_idx_d;
  logic             err_q, err_d;

  logic             busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic             load_req_q, load_req_d, core_start_q, core_start_d;
  logic             psum_clear_q, psum_clear_d, psum_last_q, psum_last_d;
  logic             flush_req_q, flush_req_d;
  logic [IDX_W-1:0] load_oc_idx_q, load_oc_idx_d, load_ic_idx_q, load_ic_idx_d;
  logic [IDX_W-1:0] flush_oc_idx_q, flush_oc_idx_d;
  logic [7:0]       core_oc_q, core_oc_d;
  logic [9:0]       core_ic_q, core_ic_d;

  // Tile counts and remaining-channel arithmetic in 11 bits so 512 plus rounding never wraps.
  logic [10:0] n_ic_w, n_oc_w, ic_rem, oc_rem;
  logic [9:0]  core_ic_w;
  logic [7:0]  core_oc_w;

  assign n_ic_w    = ({1'b0, TOTAL_IC} + 11'(IC_TILE - 1)) >> IC_SH;
  assign n_oc_w    = ({1'b0, TOTAL_OC} + 11'(OC_TILE - 1)) >> OC_SH;
  assign ic_rem    = {1'b0, tot_ic_q} - (11'(ic_idx_q) << IC_SH);
  assign oc_rem    = {1'b0, tot_oc_q} - (11'(oc_idx_q) << OC_SH);
  assign core_ic_w = (ic_rem >= 11'(IC_TILE)) ? 10'(IC_TILE) : ic_rem[9:0];
  assign core_oc_w = (oc_rem >= 11'(OC_TILE)) ? 8'(OC_TILE) : oc_rem[7:0];

  always_comb begin
    state_d   = state_q;
    tot_ic_d  = tot_ic_q;
    tot_oc_d  = tot_oc_q;
    ic_last_d = ic_last_q;
    oc_last_d = oc_last_q;
    ic_idx_d  = ic_idx_q;
    oc_idx_d  = oc_idx_q;
    err_d     = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tot_ic_d  = TOTAL_IC;
          tot_oc_d  = TOTAL_OC;
          ic_last_d = IDX_W'(n_ic_w - 11'd1);
          oc_last_d = IDX_W'(n_oc_w - 11'd1);
          ic_idx_d  = '0;
          oc_idx_d  = '0;
          err_d     = (TOTAL_IC == '0) || (TOTAL_OC == '0);
          state_d   = err_d ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (load_req_q && load_ack) state_d = S_START;
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (core_done) begin
          if (ic_idx_q == ic_last_q) begin
            state_d = S_FLUSH;
          end else begin
            ic_idx_d = ic_idx_q + IDX_W'(1);
            state_d  = S_LOAD;
          end
        end
      end
      S_FLUSH: begin
        if (flush_req_q && flush_ack) begin
          if (oc_idx_q == oc_last_q) begin
            state_d = S_DONE;
          end else begin
            oc_idx_d = oc_idx_q + IDX_W'(1);
            ic_idx_d = '0;
            state_d  = S_LOAD;
          end
        end
      end
      // The config-error path enters DONE straight from IDLE and pulses one cycle later.
      S_DONE: begin
        if (done_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE) && (state_q != S_IDLE);
    cfg_err_d      = done_d && err_q;
    load_req_d     = (state_d == S_LOAD);
    load_oc_idx_d  = (state_d == S_LOAD) ? oc_idx_d : load_oc_idx_q;
    load_ic_idx_d  = (state_d == S_LOAD) ? ic_idx_d : load_ic_idx_q;
    core_start_d   = (state_d == S_START);
    psum_clear_d   = (state_d == S_START) && (ic_idx_q == '0);
    psum_last_d    = (state_d == S_START) && (ic_idx_q == ic_last_q);
    core_oc_d      = (state_d == S_START) ? core_oc_w : core_oc_q;
    core_ic_d      = (state_d == S_START) ? core_ic_w : core_ic_q;
    flush_req_d    = (state_d == S_FLUSH);
    flush_oc_idx_d = (state_d == S_FLUSH) ? oc_idx_q : flush_oc_idx_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      tot_ic_q       <= '0;
      tot_oc_q       <= '0;
      ic_last_q      <= '0;
      oc_last_q      <= '0;
      ic_idx_q       <= '0;
      oc_idx_q       <= '0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      cfg_err_q      <= 1'b0;
      load_req_q     <= 1'b0;
      load_oc_idx_q  <= '0;
      load_ic_idx_q  <= '0;
      core_start_q   <= 1'b0;
      psum_clear_q   <= 1'b0;
      psum_last_q    <= 1'b0;
      core_oc_q      <= '0;
      core_ic_q      <= '0;
      flush_req_q    <= 1'b0;
      flush_oc_idx_q <= '0;
    end else begin
      state_q        <= state_d;
      tot_ic_q       <= tot_ic_d;
      tot_oc_q       <= tot_oc_d;
      ic_last_q      <= ic_last_d;
      oc_last_q      <= oc_last_d;
      ic_idx_q       <= ic_idx_d;
      oc_idx_q       <= oc_idx_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      cfg_err_q      <= cfg_err_d;
      load_req_q     <= load_req_d;
      load_oc_idx_q  <= load_oc_idx_d;
      load_ic_idx_q  <= load_ic_idx_d;
      core_start_q   <= core_start_d;
      psum_clear_q   <= psum_clear_d;
      psum_last_q    <= psum_last_d;
      core_oc_q      <= core_oc_d;
      core_ic_q      <= core_ic_d;
      flush_req_q    <= flush_req_d;
      flush_oc_idx_q <= flush_oc_idx_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
  assign load_req     = load_req_q;
  assign load_oc_idx  = load_oc_idx_q;
  assign load_ic_idx  = load_ic_idx_q;
  assign core_start   = core_start_q;
  assign psum_clear   = psum_clear_q;
  assign psum_last    = psum_last_q;
  assign core_oc      = core_oc_q;
  assign core_ic      = core_ic_q;
  assign flush_req    = flush_req_q;
  assign flush_oc_idx = flush_oc_idx_q;

endmodule

// File: doc/dense_tile_scheduler.md
Name: dense_tile_scheduler

Overview:
- Sequences one dense_core over a full convolution layer.
- Loops output-channel tiles (outer) and input-channel tiles (inner). Per tile it requests an operand load, pulses core_start, waits for core_done, then requests a psum writeback after the last IC tile of each OC tile.
- Sits between the layer-level control registers / DMA (act_n_weight_ctrlr side) and dense_core.

Parameters:
- OC_TILE, 32, output channels per core pass (power of two).
- IC_TILE, 64, input channels per core pass (power of two).
- IDX_W, 5, width of tile index counters.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  layer start pulse; sampled only in IDLE
- TOTAL_IC  in  10  layer input channels (1..512)
- TOTAL_OC  in  10  layer output channels (1..512)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at layer end
- cfg_err  out  1  one-cycle pulse, coincident with done, when latched TOTAL_IC==0 or TOTAL_OC==0
- load_req  out  1  operand load request; held until acknowledged
- load_ack  in  1  load complete
- load_oc_idx  out  IDX_W  OC tile index for the load
- load_ic_idx  out  IDX_W  IC tile index for the load
- core_start  out  1  one-cycle start pulse to dense_core
- core_done  in  1  dense_core completion (level or pulse)
- core_oc  out  8  channels in the current OC tile
- core_ic  out  10  channels in the current IC tile
- psum_clear  out  1  with core_start: first IC tile, accumulator starts from zero
- psum_last  out  1  with core_start: last IC tile of the OC tile
- flush_req  out  1  psum writeback request; held until acknowledged
- flush_ack  in  1  writeback complete
- flush_oc_idx  out  IDX_W  OC tile being written back

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, latched config 0. Reset is asynchronous and aborts any operation; nothing is resumed afterwards.
- All outputs are registered.
- States: IDLE, LOAD, START, RUN, FLUSH, DONE.
- IDLE:
  - On start, latch TOTAL_IC/TOTAL_OC and compute n_ic = ceil(TOTAL_IC/IC_TILE), n_oc = ceil(TOTAL_OC/OC_TILE) using shifts.
  - Clear ic_idx and oc_idx.
  - If either total is zero, go to DONE with cfg_err. Otherwise go to LOAD.
  - start while busy is ignored. Config inputs are not used after latching.
- LOAD:
  - load_req=1, load_oc_idx=oc_idx, load_ic_idx=ic_idx.
  - load_ack is honoured only when load_req is already 1.
  - On ack: load_req=0 next cycle and go to START.
- START (exactly 1 cycle):
  - core_start=1.
  - psum_clear=(ic_idx==0); psum_last=(ic_idx==n_ic-1).
  - core_oc = min(OC_TILE, TOTAL_OC - oc_idx*OC_TILE).
  - core_ic = min(IC_TILE, TOTAL_IC - ic_idx*IC_TILE).
  - core_oc/core_ic stay stable from START until the next load.
  - core_done is ignored in this cycle. Next state: RUN.
- RUN:
  - Wait for core_done=1.
  - If ic_idx==n_ic-1, go to FLUSH. Otherwise increment ic_idx and go to LOAD.
- FLUSH:
  - flush_req=1, flush_oc_idx=oc_idx; held until flush_ack is sampled with flush_req high.
  - On ack: if oc_idx==n_oc-1, go to DONE. Otherwise increment oc_idx, set ic_idx=0, go to LOAD.
- DONE: done=1 for one cycle, then IDLE; busy drops in the same cycle as the IDLE entry.
- Latency (n_ic=n_oc=1, ack/core_done returned the cycle after request):
  - start sampled at cycle 0.
  - load_req at 1, ack at 2, core_start at 3.
  - core_done at 4, flush_req at 5, ack at 6.
  - done at 7.
- Width rules:
  - Tile count arithmetic uses 11 bits.
  - core_oc saturates to 8 bits; the maximum value is OC_TILE.

Test Plan:
- TOTAL_IC=64, TOTAL_OC=32, immediate acks -> one load (0,0); core_start with psum_clear=1, psum_last=1, core_oc=32, core_ic=64; one flush (0); done at cycle 7 after start.
- TOTAL_IC=130, TOTAL_OC=70 -> load order (oc,ic) = (0,0)(0,1)(0,2)(1,0)…(2,2); core_ic = 64,64,2; core_oc = 32,32,6; psum_clear only on ic=0; psum_last only on ic=2; flushes at oc 0,1,2; 9 core_start pulses total.
- load_ack delayed 5 cycles; flush_ack delayed 10 cycles; core_done held high for 3 cycles -> requests stay high until ack; exactly one core_start per tile; no extra tile is issued.
- start pulsed while busy, and core_done asserted during the START cycle -> both ignored; sequence identical to the undisturbed run.
- TOTAL_OC=0 -> no load_req or core_start; done and cfg_err pulse together 2 cycles after start.
- resetn low mid-RUN -> all outputs 0 immediately; after release, a new start runs the full sequence from tile (0,0).
